// File: rtl/mem_access.sv
// MEM stage: byte-serial loads/stores over a shared, arbitrated RAM port.
// Optional MEM_MISALIGN_CHECK_EN adds misalign_o and rejects unaligned H/W accesses.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] memaddr_i,
  input  logic              memwr_i,
  input  logic [1:0]        memcnf_i,
  input  logic              memsigned_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              misalign_o,
`endif
  output logic              mem_stall
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_FINISH} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr, r_signed, r_wreg;
  logic [2:0]          r_n, r_idx, w_n;
  logic [4:0]          r_wd;
  logic [DATA_W-1:0]   r_wdata, r_asm, w_load_val;
  logic                w_misalign, w_start;
  logic [1:0]          w_byte;

  always_comb begin
    case (memcnf_i)
      2'd1:    w_n = 3'd1;
      2'd2:    w_n = 3'd2;
      default: w_n = 3'd4;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = (memcnf_i == 2'd2 && memaddr_i[0]) ||
                      (memcnf_i == 2'd3 && memaddr_i[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start = (r_state == S_IDLE) && (memcnf_i != 2'd0) && !w_misalign;
  // Load byte arriving now belongs to the address issued one cycle earlier.
  assign w_byte  = r_idx[1:0] - 2'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_signed <= 1'b0;
      r_wreg   <= 1'b0;
      r_n      <= 3'd0;
      r_idx    <= 3'd0;
      r_wd     <= 5'd0;
      r_wdata  <= '0;
      r_asm    <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr   <= memaddr_i;
        r_wr     <= memwr_i;
        r_signed <= memsigned_i;
        r_wreg   <= wreg_i;
        r_n      <= w_n;
        r_wd     <= wd_i;
        r_wdata  <= wdata_i;
        r_asm    <= '0;
      end
      if (r_state == S_REQ) r_idx <= 3'd0;
      if (r_state == S_XFER) begin
        r_idx <= r_idx + 3'd1;
        if (!r_wr && r_idx != 3'd0) r_asm[{w_byte, 3'b000} +: 8] <= mem_din_i;
      end
    end
  end

  always_comb begin
    case (r_n)
      3'd1:    w_load_val = {{(DATA_W-8){r_signed & r_asm[7]}}, r_asm[7:0]};
      3'd2:    w_load_val = {{(DATA_W-16){r_signed & r_asm[15]}}, r_asm[15:0]};
      default: w_load_val = r_asm;
    endcase
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    w_next     = r_state;
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    mem_req_o  = 1'b0;
    mem_a_o    = '0;
    mem_wr_o   = 1'b0;
    mem_dout_o = 8'd0;
    mem_stall  = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign_o = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (memcnf_i == 2'd0) begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end else if (w_misalign) begin
          wd_o = wd_i;
`ifdef MEM_MISALIGN_CHECK_EN
          misalign_o = 1'b1;
`endif
        end else begin
          mem_stall = 1'b1;
          w_next    = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_o = 1'b1;
        mem_stall = 1'b1;
        if (mem_gnt_i) w_next = S_XFER;
      end
      S_XFER: begin
        mem_req_o = 1'b1;
        mem_stall = 1'b1;
        if (r_wr) begin
          mem_a_o    = r_addr + ADDR_W'(r_idx);
          mem_wr_o   = 1'b1;
          mem_dout_o = r_wdata[{r_idx[1:0], 3'b000} +: 8];
          if (r_idx == r_n - 3'd1) w_next = S_FINISH;
        end else begin
          if (r_idx < r_n) mem_a_o = r_addr + ADDR_W'(r_idx);
          if (r_idx == r_n) w_next = S_FINISH;
        end
      end
      S_FINISH: begin
        wd_o    = r_wd;
        wreg_o  = r_wreg & ~r_wr;
        wdata_o = r_wr ? '0 : w_load_val;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
